qspi_fb_writer: RTL and testbench

// - Downstream of the QSPI slave receiver: consumes its 16-bit word stream plus header (command, length, address).
// - Converts each write packet into sequential write strobes on the QSPI_CLK-side port of the menu/overlay framebuffer BRAM.
// - Enforces packet length and framebuffer bounds, and reports done, overrun and reject status for the current transaction.

---
 rtl/qspi_fb_pkg.sv | 26 ++
 rtl/qspi_fb_csum.sv | 49 ++++
 rtl/qspi_fb_writer.sv | 241 ++++++++++++++++++++++++
 tb/tb_qspi_fb_writer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_fb_pkg.sv
// -----------------------------------------------------------------------------
// qspi_fb_pkg
// Shared definitions for the QSPI framebuffer writer path:
//   - fbWrState_t    : writer FSM states (IDLE, STREAM, DRAIN)
//   - QSPI_MAX_WORDS : word count encoded by a zero length field
//   - FB_ADDR_W_DEFAULT / FB_DEPTH_DEFAULT : framebuffer geometry, also used
//     by the framebuffer RAM and the display-side reader
//   - swapBytes()    : byte-lane swap of a 16-bit word
// -----------------------------------------------------------------------------
package qspi_fb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } fbWrState_t;

    localparam int QSPI_MAX_WORDS    = 1024;
    localparam int FB_ADDR_W_DEFAULT = 11;
    localparam int FB_DEPTH_DEFAULT  = 1440;

    function automatic logic [15:0] swapBytes(input logic [15:0] word);
        return {word[7:0], word[15:8]};
    endfunction

endpackage

// File: rtl/qspi_fb_csum.sv
// -----------------------------------------------------------------------------
// qspi_fb_csum
// Modulo-2^16 running sum of the words written to the framebuffer.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-high reset (clears the sum)
//   en    in   add data this cycle
//   clear in   restart the sum from zero (data is still added when en = 1)
//   data  in   16-bit word to accumulate
//   sum   out  registered running sum
// -----------------------------------------------------------------------------
module qspi_fb_csum (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [15:0] data,
    output logic [15:0] sum
);

    logic [15:0] addend_s;
    logic [15:0] start_s;

    // Select the operands of the next accumulation step.
    always_comb begin
        addend_s = 16'h0000;
        start_s  = sum;
        if (en) begin
            addend_s = data;
        end else begin
            addend_s = 16'h0000;
        end
        if (clear) begin
            start_s = 16'h0000;
        end else begin
            start_s = sum;
        end
    end

    // Accumulator register; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= 16'h0000;
        end else begin
            sum <= start_s + addend_s;
        end
    end

endmodule

// File: rtl/qspi_fb_writer.sv
// -----------------------------------------------------------------------------
// qspi_fb_writer
// Turns one QSPI write packet (header + 16-bit word stream) into sequential
// write strobes on the QSPI_CLK-side port of the menu/overlay framebuffer.
// Enforces packet length and framebuffer bounds; reports done/overrun/reject.
// QSPI_CS high is the asynchronous reset: it ends (or aborts) a transaction.
//
// Optional feature: define QSPI_FB_WR_CHECKSUM_EN to add wrChecksum, the
// modulo-2^16 sum of every written word, final in the wrDone cycle.
//
// Ports:
//   QSPI_CLK    in   clock, all state on posedge
//   QSPI_CS     in   async active-high reset (chip-select high = idle/abort)
//   qCommand    in   1 = write packet, 0 = ignored packet
//   qLength     in   [9:0] length in words, 0 encodes 1024
//   qAddress    in   [31:0] start word address
//   qDataValid  in   one-cycle strobe per received word
//   qData       in   [15:0] received word
//   fbWrEn      out  BRAM write enable (one cycle per accepted word)
//   fbWrAddr    out  [FB_ADDR_W-1:0] BRAM word address
//   fbWrData    out  [15:0] BRAM write data
//   wrBusy      out  packet accepted, not yet complete
//   wrDone      out  pulse with the final in-length write
//   wrOverrun   out  sticky: a word was dropped (length or bounds)
//   wrReject    out  sticky: start address out of range, packet dropped
//   wrCount     out  [10:0] words written this transaction
//   wrChecksum  out  [15:0] (QSPI_FB_WR_CHECKSUM_EN only) running data sum
// -----------------------------------------------------------------------------
module qspi_fb_writer
    import qspi_fb_pkg::*;
#(
    parameter int FB_ADDR_W  = FB_ADDR_W_DEFAULT,
    parameter int FB_DEPTH   = FB_DEPTH_DEFAULT,
    parameter bit SWAP_BYTES = 1'b1
) (
    input  logic                 QSPI_CLK,
    input  logic                 QSPI_CS,
    input  logic                 qCommand,
    input  logic [9:0]           qLength,
    input  logic [31:0]          qAddress,
    input  logic                 qDataValid,
    input  logic [15:0]          qData,
    output logic                 fbWrEn,
    output logic [FB_ADDR_W-1:0] fbWrAddr,
    output logic [15:0]          fbWrData,
    output logic                 wrBusy,
    output logic                 wrDone,
    output logic                 wrOverrun,
    output logic                 wrReject,
    output logic [10:0]          wrCount
`ifdef QSPI_FB_WR_CHECKSUM_EN
    ,
    output logic [15:0]          wrChecksum
`endif
);

    // Address arithmetic is wide enough that base + count never wraps.
    localparam int                SUM_W     = ((FB_ADDR_W > 11) ? FB_ADDR_W : 11) + 1;
    localparam logic [SUM_W-1:0]  DEPTH_SUM = SUM_W'(FB_DEPTH);
    localparam logic [31:0]       DEPTH_32  = 32'(FB_DEPTH);
    localparam logic [10:0]       MAX_WORDS = 11'(QSPI_MAX_WORDS);

    fbWrState_t           state_r;
    fbWrState_t           nextState_s;

    logic [FB_ADDR_W-1:0] base_r;
    logic [10:0]          len_r;
    logic                 isWrite_r;

    logic [10:0]          lenDecoded_s;
    logic [SUM_W-1:0]     streamAddrFull_s;
    logic                 inBounds_s;
    logic                 streamLast_s;
    logic                 startWrite_s;
    logic                 startReject_s;
    logic                 streamWrite_s;
    logic                 streamDrop_s;
    logic                 drainDrop_s;
    logic                 accept_s;
    logic [15:0]          wrData_s;

    logic                 fbWrEn_s;
    logic [FB_ADDR_W-1:0] fbWrAddr_s;
    logic [15:0]          fbWrData_s;
    logic                 wrBusy_s;
    logic                 wrDone_s;
    logic                 wrOverrun_s;
    logic                 wrReject_s;
    logic [10:0]          wrCount_s;

    // Decode the header and classify the incoming word for the current state.
    always_comb begin
        lenDecoded_s     = (qLength == 10'd0) ? MAX_WORDS : {1'b0, qLength};
        streamAddrFull_s = SUM_W'(base_r) + SUM_W'(wrCount_r_view());
        inBounds_s       = (streamAddrFull_s < DEPTH_SUM);
        streamLast_s     = ((wrCount + 11'd1) == len_r);
        wrData_s         = SWAP_BYTES ? swapBytes(qData) : qData;

        // Header is only looked at together with the first qDataValid.
        startWrite_s  = (state_r == IDLE) && qDataValid && qCommand && (qAddress < DEPTH_32);
        startReject_s = (state_r == IDLE) && qDataValid && qCommand && !(qAddress < DEPTH_32);
        streamWrite_s = (state_r == STREAM) && qDataValid && inBounds_s;
        streamDrop_s  = (state_r == STREAM) && qDataValid && !inBounds_s;
        drainDrop_s   = (state_r == DRAIN) && qDataValid && isWrite_r;
        accept_s      = startWrite_s || streamWrite_s;
    end

    // wrCount is the registered output itself; this keeps the intent readable.
    function automatic logic [10:0] wrCount_r_view();
        return wrCount;
    endfunction

    // FSM state register.
    always_ff @(posedge QSPI_CLK or posedge QSPI_CS) begin
        if (QSPI_CS) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic; DRAIN is only left through reset.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (qDataValid) begin
                    if (startWrite_s && (lenDecoded_s != 11'd1)) begin
                        nextState_s = STREAM;
                    end else begin
                        nextState_s = DRAIN;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            STREAM: begin
                if (qDataValid) begin
                    if (!inBounds_s || streamLast_s) begin
                        nextState_s = DRAIN;
                    end else begin
                        nextState_s = STREAM;
                    end
                end else begin
                    nextState_s = STREAM;
                end
            end
            DRAIN: begin
                nextState_s = DRAIN;
            end
            default: begin
                nextState_s = DRAIN;
            end
        endcase
    end

    // FSM output logic: next values of all registered outputs.
    always_comb begin
        fbWrEn_s    = accept_s;
        fbWrAddr_s  = fbWrAddr;
        fbWrData_s  = fbWrData;
        wrDone_s    = 1'b0;
        wrOverrun_s = wrOverrun || streamDrop_s || drainDrop_s;
        wrReject_s  = wrReject || startReject_s;
        wrBusy_s    = (nextState_s == STREAM) || startWrite_s;
        wrCount_s   = wrCount;

        if (startWrite_s) begin
            fbWrAddr_s = qAddress[FB_ADDR_W-1:0];
            fbWrData_s = wrData_s;
            wrDone_s   = (lenDecoded_s == 11'd1);
        end else if (streamWrite_s) begin
            fbWrAddr_s = streamAddrFull_s[FB_ADDR_W-1:0];
            fbWrData_s = wrData_s;
            wrDone_s   = streamLast_s;
        end else begin
            fbWrAddr_s = fbWrAddr;
            fbWrData_s = fbWrData;
            wrDone_s   = 1'b0;
        end

        if (accept_s && (wrCount != MAX_WORDS)) begin
            wrCount_s = wrCount + 11'd1;
        end else begin
            wrCount_s = wrCount;
        end
    end

    // Output registers; address/data hold their last values between writes.
    always_ff @(posedge QSPI_CLK or posedge QSPI_CS) begin
        if (QSPI_CS) begin
            fbWrEn    <= 1'b0;
            fbWrAddr  <= '0;
            fbWrData  <= 16'h0000;
            wrBusy    <= 1'b0;
            wrDone    <= 1'b0;
            wrOverrun <= 1'b0;
            wrReject  <= 1'b0;
            wrCount   <= 11'd0;
        end else begin
            fbWrEn    <= fbWrEn_s;
            fbWrAddr  <= fbWrAddr_s;
            fbWrData  <= fbWrData_s;
            wrBusy    <= wrBusy_s;
            wrDone    <= wrDone_s;
            wrOverrun <= wrOverrun_s;
            wrReject  <= wrReject_s;
            wrCount   <= wrCount_s;
        end
    end

    // Packet context captured with the first accepted word.
    always_ff @(posedge QSPI_CLK or posedge QSPI_CS) begin
        if (QSPI_CS) begin
            base_r    <= '0;
            len_r     <= 11'd0;
            isWrite_r <= 1'b0;
        end else if (startWrite_s) begin
            base_r    <= qAddress[FB_ADDR_W-1:0];
            len_r     <= lenDecoded_s;
            isWrite_r <= 1'b1;
        end else begin
            base_r    <= base_r;
            len_r     <= len_r;
            isWrite_r <= isWrite_r;
        end
    end

`ifdef QSPI_FB_WR_CHECKSUM_EN
    // Sum is updated on the same edge as fbWrData, so it is final with wrDone.
    qspi_fb_csum uCsum (
        .clk   (QSPI_CLK),
        .rst   (QSPI_CS),
        .en    (accept_s),
        .clear (startWrite_s),
        .data  (wrData_s),
        .sum   (wrChecksum)
    );
`endif

endmodule

// File: tb/tb_qspi_fb_writer.sv
// -----------------------------------------------------------------------------
// tb_qspi_fb_writer
// Randomized and directed packets; a reference model derives the expected
// writes from the packet rules and queues them; a negedge monitor pops and
// compares every fbWrEn cycle. End-of-packet flags are checked per packet.
// -----------------------------------------------------------------------------
module tb_qspi_fb_writer;

    localparam int DEPTH = 1440;
    localparam int AW    = 11;

    logic          clk;
    logic          cs;
    logic          qCommand;
    logic [9:0]    qLength;
    logic [31:0]   qAddress;
    logic          qDataValid;
    logic [15:0]   qData;
    logic          fbWrEn;
    logic [AW-1:0] fbWrAddr;
    logic [15:0]   fbWrData;
    logic          wrBusy;
    logic          wrDone;
    logic          wrOverrun;
    logic          wrReject;
    logic [10:0]   wrCount;
`ifdef QSPI_FB_WR_CHECKSUM_EN
    logic [15:0]   wrChecksum;
`endif

    qspi_fb_writer #(.FB_ADDR_W(AW), .FB_DEPTH(DEPTH), .SWAP_BYTES(1'b1)) dut (
        .QSPI_CLK   (clk),
        .QSPI_CS    (cs),
        .qCommand   (qCommand),
        .qLength    (qLength),
        .qAddress   (qAddress),
        .qDataValid (qDataValid),
        .qData      (qData),
        .fbWrEn     (fbWrEn),
        .fbWrAddr   (fbWrAddr),
        .fbWrData   (fbWrData),
        .wrBusy     (wrBusy),
        .wrDone     (wrDone),
        .wrOverrun  (wrOverrun),
        .wrReject   (wrReject),
        .wrCount    (wrCount)
`ifdef QSPI_FB_WR_CHECKSUM_EN
        ,
        .wrChecksum (wrChecksum)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
        logic          done;
        logic [15:0]   csum;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] words[$];
    int          checks = 0;
    int          errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the next expected write.
    always @(negedge clk) begin
        exp_t e;
        if (!cs) begin
            if (fbWrEn) begin
                if (expQ.size() == 0) begin
                    check("unexpected_write_addr", 32'(fbWrAddr), 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    check("wr_addr", 32'(fbWrAddr), 32'(e.addr));
                    check("wr_data", 32'(fbWrData), 32'(e.data));
                    check("wr_done", 32'(wrDone), 32'(e.done));
`ifdef QSPI_FB_WR_CHECKSUM_EN
                    if (e.done) check("checksum", 32'(wrChecksum), 32'(e.csum));
`endif
                end
            end else if (wrDone) begin
                check("done_without_write", 32'(wrDone), 32'd0);
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_fbWrEn"},    32'(fbWrEn),    32'd0);
        check({tag, "_fbWrAddr"},  32'(fbWrAddr),  32'd0);
        check({tag, "_fbWrData"},  32'(fbWrData),  32'd0);
        check({tag, "_wrBusy"},    32'(wrBusy),    32'd0);
        check({tag, "_wrDone"},    32'(wrDone),    32'd0);
        check({tag, "_wrOverrun"}, 32'(wrOverrun), 32'd0);
        check({tag, "_wrReject"},  32'(wrReject),  32'd0);
        check({tag, "_wrCount"},   32'(wrCount),   32'd0);
`ifdef QSPI_FB_WR_CHECKSUM_EN
        check({tag, "_wrChecksum"}, 32'(wrChecksum), 32'd0);
`endif
    endtask

    // Sends the words in 'words' as one packet, then raises CS.
    task automatic runPacket(input bit cmd, input logic [31:0] addr, input logic [9:0] lenField);
        int          lenWords;
        int          written;
        bit          dropped;
        bit          accepted;
        logic [15:0] sw;
        logic [15:0] w;
        logic [15:0] csum;
        exp_t        e;

        lenWords = (lenField == 10'd0) ? 1024 : int'(lenField);
        accepted = cmd && (longint'(addr) < longint'(DEPTH));
        written  = 0;
        dropped  = 1'b0;
        csum     = 16'h0000;

        @(posedge clk); #1;
        cs = 1'b0; qCommand = cmd; qLength = lenField; qAddress = addr;
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            if (accepted) begin
                if (i < lenWords && (longint'(addr) + i) < longint'(DEPTH)) begin
                    sw     = {w[7:0], w[15:8]};
                    csum   = csum + sw;
                    e.addr = AW'(addr + 32'(i));
                    e.data = sw;
                    e.done = (i == lenWords - 1);
                    e.csum = csum;
                    expQ.push_back(e);
                    written++;
                end else begin
                    dropped = 1'b1;
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                qDataValid = 1'b0;
                @(posedge clk); #1;
            end
            qDataValid = 1'b1;
            qData      = w;
            @(posedge clk); #1;
        end
        qDataValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", 32'(expQ.size()), 32'd0);
        check("wrCount",   32'(wrCount),   32'(written));
        check("wrOverrun", 32'(wrOverrun), 32'(accepted && dropped));
        check("wrReject",  32'(wrReject),  32'(cmd && !accepted));
        check("wrBusy",    32'(wrBusy),    32'(accepted && !dropped && written < lenWords));
        expQ.delete();
        cs = 1'b1;
        #1;
        checkIdleOutputs("after_cs");
        @(posedge clk); #1;
        words.delete();
    endtask

    task automatic randomWords(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    initial begin
        logic [31:0] a;
        cs = 1'b1; qCommand = 1'b0; qLength = 10'd0; qAddress = 32'd0;
        qDataValid = 1'b0; qData = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");

        // Basic write with byte swap.
        words = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
        runPacket(1'b1, 32'h10, 10'd4);

        // Length overrun: 3 words into a 2-word packet.
        randomWords(3);
        runPacket(1'b1, 32'h200, 10'd2);

        // Bounds: only the last two framebuffer words are writable.
        randomWords(4);
        runPacket(1'b1, 32'(DEPTH - 2), 10'd4);

        // Rejected start address, then a non-write packet.
        randomWords(3);
        runPacket(1'b1, 32'(DEPTH), 10'd4);
        randomWords(8);
        runPacket(1'b0, 32'h40, 10'd8);

        // Abort after 3 of 8 words, then a zero-length (1024-word) packet.
        randomWords(3);
        runPacket(1'b1, 32'h80, 10'd8);
        randomWords(1024);
        runPacket(1'b1, 32'h20, 10'd0);

        // Single-word packet and checksum carry pattern.
        randomWords(1);
        runPacket(1'b1, 32'h5, 10'd1);
        words = '{16'hFFFF, 16'h0002};
        runPacket(1'b1, 32'h30, 10'd2);

        // Randomized packets.
        for (int p = 0; p < 25; p++) begin
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(DEPTH - 20, DEPTH + 60));
            else                           a = 32'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 15) == 0) a = 32'hFFFF_0000;
            randomWords($urandom_range(1, 24));
            runPacket($urandom_range(0, 5) != 0, a, 10'($urandom_range(1, 20)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
